bus_rr_sched: RTL and testbench

- Round-robin scheduler for the shared packet bus between `drvrs` agent FIFOs.
- Each cycle it watches the per-driver pending flags and grants one source.
- It pops one packet from the granted source and decodes the destination ID from the packet MSBs.
- It then pushes the packet to one destination FIFO, or to all others on broadcast, while honouring destination backpressure.

---
 rtl/bus_sched_pkg.sv | 21 ++
 rtl/rr_pick.sv | 31 +++
 rtl/bus_rr_sched.sv | 156 +++++++++++++++
 tb/tb_bus_rr_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sched_pkg.sv
// Shared types and helpers for the round-robin packet bus scheduler.
// Optional wait-timeout logic in bus_rr_sched is enabled by BUS_RR_SCHED_TIMEOUT_EN.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    DISPATCH
  } state_t;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 64;
  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  // Destination ID lives in the top ID_W bits of an sz-bit packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int                   sz);
    return ID_W'(pkt >> (sz - ID_W));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request strictly after ptr,
// wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = ptr;
    for (int i = 0; i < N; i++) begin
      j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
      if (!vld && req[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
    if (vld) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin scheduler moving packets from driver FIFOs to destination FIFOs.
// Define BUS_RR_SCHED_TIMEOUT_EN to drop packets blocked for TIMEOUT cycles.
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 32,
  parameter logic [ID_W-1:0] BROADCAST = BROADCAST_ID,
  parameter int              TIMEOUT   = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DRVRS-1:0]                pndng,
  input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]                full,
  output logic [DRVRS-1:0]                pop,
  output logic [DRVRS-1:0]                push,
  output logic [PCKG_SZ-1:0]              D_push,
  output logic [$clog2(DRVRS)-1:0]        grant_id,
  output logic                            busy,
  output logic                            err_dest,
  output logic [15:0]                     pkt_cnt
);

  localparam int IW = $clog2(DRVRS);

  if (DRVRS < 2 || DRVRS > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bus_rr_sched: unsupported parameter set");
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t               state_q;
  logic [DRVRS-1:0]     pop_q, push_q;
  logic [PCKG_SZ-1:0]   data_q, dpush_q;
  logic [IW-1:0]        grant_q, ptr_q;
  logic                 err_q, done_q;
  logic [15:0]          cnt_q;

  logic [DRVRS-1:0]     rr_gnt;
  logic [IW-1:0]        rr_idx;
  logic                 rr_vld;

  rr_pick #(.N(DRVRS), .IW(IW)) u_pick (
    .req (pndng),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .vld (rr_vld)
  );

  // Dispatch is first attempted on the POP cycle straight from the FIFO head,
  // so an unblocked packet pushes on the cycle right after its pop.
  logic [PCKG_SZ-1:0] cand;
  logic [ID_W-1:0]    dest;
  logic [DRVRS-1:0]   tgt, src_oh;
  logic               dest_bad, dest_ok, fire;

  always_comb begin
    cand     = (state_q == POP) ? D_pop[grant_q] : data_q;
    dest     = dest_of(PKT_MAX_W'(cand), PCKG_SZ);
    src_oh   = '0;
    src_oh[grant_q] = 1'b1;
    tgt      = '0;
    dest_bad = 1'b0;
    if (dest < ID_W'(DRVRS))  tgt[dest[IW-1:0]] = 1'b1;
    else if (dest == BROADCAST) tgt = ~src_oh;
    else                        dest_bad = 1'b1;
    dest_ok  = !dest_bad && ((tgt & full) == '0);
    fire     = (state_q == POP) || (state_q == DISPATCH && !done_q);
  end

`ifdef BUS_RR_SCHED_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pop_q   <= '0;
      push_q  <= '0;
      dpush_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      grant_q <= '0;
      ptr_q   <= IW'(DRVRS - 1);
`ifdef BUS_RR_SCHED_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      pop_q  <= '0;
      push_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rr_vld) begin
            grant_q <= rr_idx;
            ptr_q   <= rr_idx;
            pop_q   <= rr_gnt;
            state_q <= POP;
          end
        end
        POP: begin
          data_q  <= D_pop[grant_q];
          state_q <= DISPATCH;
`ifdef BUS_RR_SCHED_TIMEOUT_EN
          wait_q  <= '0;
`endif
        end
        DISPATCH: begin
          if (done_q) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (fire) begin
        if (dest_bad) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
        end else if (dest_ok) begin
          push_q  <= tgt;
          dpush_q <= cand;
          cnt_q   <= sat_inc(cnt_q);
          done_q  <= 1'b1;
        end
`ifdef BUS_RR_SCHED_TIMEOUT_EN
        else if (state_q == DISPATCH) begin
          if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
`endif
      end
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);
  assign err_dest = err_q;
  assign pkt_cnt  = cnt_q;

endmodule

// File: tb/tb_bus_rr_sched.sv
// Scoreboard bench for bus_rr_sched (DRVRS=4, PCKG_SZ=32) with behavioural source FIFOs.
module tb_bus_rr_sched;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       pndng;
  logic [3:0][31:0] D_pop;
  logic [3:0]       full;
  logic [3:0]       pop;
  logic [3:0]       push;
  logic [31:0]      D_push;
  logic [1:0]       grant_id;
  logic             busy;
  logic             err_dest;
  logic [15:0]      pkt_cnt;

  bus_rr_sched dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .full     (full),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .grant_id (grant_id),
    .busy     (busy),
    .err_dest (err_dest),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] mask; logic [31:0] data; } push_t;
  typedef struct { int idx; logic [1:0] gid; int cyc; } pop_t;

  int    checks = 0, failures = 0;
  int    cyc = 0, err_seen = 0, err_cyc = 0, overlap = 0;
  push_t exp_push[$];
  push_t obs_push[$];
  pop_t  obs_pop[$];
  logic [31:0] src_q[4][$];

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      pndng[i] = (src_q[i].size() > 0);
      D_pop[i] = (src_q[i].size() > 0) ? src_q[i][0] : 32'h0;
    end
  endtask

  task automatic load(input int s, input logic [31:0] w);
    src_q[s].push_back(w);
    refresh();
  endtask

  task automatic clear_obs();
    obs_push.delete();
    obs_pop.delete();
    exp_push.delete();
    err_seen = 0;
  endtask

  task automatic tick();
    logic [3:0] p;
    p = pop;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (p[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    if (|push) obs_push.push_back(push_t'{push, D_push});
    if (|pop) begin
      int ix;
      ix = 0;
      for (int i = 0; i < 4; i++) if (pop[i]) ix = i;
      obs_pop.push_back(pop_t'{ix, grant_id, cyc});
    end
    if (err_dest) begin
      err_seen++;
      err_cyc = cyc;
    end
    if (|pop && |push) overlap++;
    refresh();
  endtask

  task automatic run_idle(input int maxc, output bit to);
    to = 1'b1;
    for (int n = 0; n < maxc; n++) begin
      tick();
      if (!busy && pndng == 4'b0) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    full  = 4'b0;
    tick();
    tick();
    checks++; if (pop !== 4'b0)       begin failures++; $display("FAIL reset_pop got=%b want=0000", pop); end
    checks++; if (push !== 4'b0)      begin failures++; $display("FAIL reset_push got=%b want=0000", push); end
    checks++; if (D_push !== 32'h0)   begin failures++; $display("FAIL reset_dpush got=%h want=0", D_push); end
    checks++; if (grant_id !== 2'd0)  begin failures++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (err_dest !== 1'b0)  begin failures++; $display("FAIL reset_err got=%b want=0", err_dest); end
    checks++; if (pkt_cnt !== 16'd0)  begin failures++; $display("FAIL reset_cnt got=%0d want=0", pkt_cnt); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    clear_obs();
    load(2, 32'h0100ABCD);
    tick();
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL single_pop got=%b want=0100", pop); end
    checks++; if (push !== 4'b0)   begin failures++; $display("FAIL single_nopush got=%b want=0000", push); end
    tick();
    checks++; if (push !== 4'b0010)      begin failures++; $display("FAIL single_push got=%b want=0010", push); end
    checks++; if (D_push !== 32'h0100ABCD) begin failures++; $display("FAIL single_data got=%h want=0100abcd", D_push); end
    checks++; if (pkt_cnt !== 16'd1)     begin failures++; $display("FAIL single_cnt got=%0d want=1", pkt_cnt); end
    checks++; if (pop !== 4'b0)          begin failures++; $display("FAIL single_pop_clear got=%b want=0000", pop); end
    tick();
    checks++; if (push !== 4'b0)         begin failures++; $display("FAIL single_push_1cyc got=%b want=0000", push); end
    checks++; if (D_push !== 32'h0100ABCD) begin failures++; $display("FAIL single_hold got=%h want=0100abcd", D_push); end
    tick();
  endtask

  task automatic test_rr_fairness();
    bit to;
    do_reset();
    clear_obs();
    for (int k = 0; k < 2; k++)
      for (int s = 0; s < 4; s++) begin
        load(s, {8'h00, 8'(s), 16'(k)});
        exp_push.push_back(push_t'{4'b0001, {8'h00, 8'(s), 16'(k)}});
      end
    run_idle(200, to);
    checks++; if (to) begin failures++; $display("FAIL rr_timeout got=busy want=idle"); end
    checks++; if (obs_pop.size() != 8) begin failures++; $display("FAIL rr_pop_count got=%0d want=8", obs_pop.size()); end
    for (int k = 0; k < obs_pop.size() && k < 8; k++) begin
      checks++;
      if (obs_pop[k].idx != k % 4 || obs_pop[k].gid !== 2'(k % 4)) begin
        failures++;
        $display("FAIL rr_order[%0d] got=%0d/gid%0d want=%0d", k, obs_pop[k].idx, obs_pop[k].gid, k % 4);
      end
      if (k > 0) begin
        checks++;
        if (obs_pop[k].cyc - obs_pop[k-1].cyc != 3) begin
          failures++;
          $display("FAIL rr_spacing[%0d] got=%0d want=3", k, obs_pop[k].cyc - obs_pop[k-1].cyc);
        end
      end
    end
    while (exp_push.size() > 0) begin
      push_t e, o;
      e = exp_push.pop_front();
      checks++;
      if (obs_push.size() == 0) begin
        failures++; $display("FAIL rr_push got=none want=%b/%h", e.mask, e.data);
      end else begin
        o = obs_push.pop_front();
        if (o.mask !== e.mask || o.data !== e.data) begin
          failures++; $display("FAIL rr_push got=%b/%h want=%b/%h", o.mask, o.data, e.mask, e.data);
        end
      end
    end
    checks++; if (pkt_cnt !== 16'd8) begin failures++; $display("FAIL rr_cnt got=%0d want=8", pkt_cnt); end
  endtask

  task automatic test_broadcast();
    bit to;
    logic [15:0] c0;
    clear_obs();
    c0 = pkt_cnt;
    load(1, 32'hFF000055);
    exp_push.push_back(push_t'{4'b1101, 32'hFF000055});
    run_idle(50, to);
    checks++; if (to) begin failures++; $display("FAIL bcast_timeout got=busy want=idle"); end
    while (exp_push.size() > 0) begin
      push_t e, o;
      e = exp_push.pop_front();
      checks++;
      if (obs_push.size() == 0) begin
        failures++; $display("FAIL bcast_push got=none want=%b/%h", e.mask, e.data);
      end else begin
        o = obs_push.pop_front();
        if (o.mask !== e.mask || o.data !== e.data) begin
          failures++; $display("FAIL bcast_push got=%b/%h want=%b/%h", o.mask, o.data, e.mask, e.data);
        end
      end
    end
    checks++; if (obs_push.size() != 0) begin failures++; $display("FAIL bcast_extra got=%0d want=0", obs_push.size()); end
    checks++; if (pkt_cnt !== c0 + 16'd1) begin failures++; $display("FAIL bcast_cnt got=%0d want=%0d", pkt_cnt, c0 + 16'd1); end
  endtask

  task automatic test_backpressure();
    clear_obs();
    full = 4'b1000;
    load(0, 32'h03001234);
    tick();
    tick();
    for (int n = 0; n < 10; n++) tick();
    checks++; if (obs_push.size() != 0) begin failures++; $display("FAIL bp_blocked got=%0d pushes want=0", obs_push.size()); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b want=1", busy); end
    full = 4'b0000;
    tick();
    checks++; if (push !== 4'b1000) begin failures++; $display("FAIL bp_push got=%b want=1000", push); end
    checks++; if (D_push !== 32'h03001234) begin failures++; $display("FAIL bp_data got=%h want=03001234", D_push); end
    tick();
    tick();
  endtask

  task automatic test_invalid_id();
    bit to;
    logic [15:0] c0;
    clear_obs();
    c0 = pkt_cnt;
    load(2, 32'h07000000);
    run_idle(50, to);
    checks++; if (to) begin failures++; $display("FAIL inv_timeout got=busy want=idle"); end
    checks++; if (err_seen != 1) begin failures++; $display("FAIL inv_err got=%0d cycles want=1", err_seen); end
    checks++; if (obs_push.size() != 0) begin failures++; $display("FAIL inv_push got=%0d want=0", obs_push.size()); end
    checks++; if (pkt_cnt !== c0) begin failures++; $display("FAIL inv_cnt got=%0d want=%0d", pkt_cnt, c0); end
  endtask

`ifdef BUS_RR_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    logic [15:0] c0;
    int pc;
    clear_obs();
    c0 = pkt_cnt;
    full = 4'b0001;
    load(1, 32'h000000AA);
    run_idle(200, to);
    full = 4'b0000;
    pc = (obs_pop.size() > 0) ? obs_pop[0].cyc : 0;
    checks++; if (to) begin failures++; $display("FAIL to_stuck got=busy want=idle"); end
    checks++; if (err_seen != 1) begin failures++; $display("FAIL to_err got=%0d want=1", err_seen); end
    checks++; if (err_cyc - pc < 64 || err_cyc - pc > 66) begin failures++; $display("FAIL to_delay got=%0d want=64..66", err_cyc - pc); end
    checks++; if (obs_push.size() != 0) begin failures++; $display("FAIL to_push got=%0d want=0", obs_push.size()); end
    checks++; if (pkt_cnt !== c0) begin failures++; $display("FAIL to_cnt got=%0d want=%0d", pkt_cnt, c0); end
  endtask
`endif

  task automatic test_reset_mid_op();
    bit to;
    clear_obs();
    full = 4'b0010;
    load(3, 32'h01000077);
    for (int n = 0; n < 5; n++) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_pre got=%b want=1", busy); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL mid_busy got=%b want=0", busy); end
    checks++; if (pop !== 4'b0 || push !== 4'b0) begin failures++; $display("FAIL mid_strobes got=%b/%b want=0000/0000", pop, push); end
    checks++; if (D_push !== 32'h0 || err_dest !== 1'b0) begin failures++; $display("FAIL mid_data got=%h/%b want=0/0", D_push, err_dest); end
    checks++; if (pkt_cnt !== 16'd0 || grant_id !== 2'd0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d want=0/0", pkt_cnt, grant_id); end
    full = 4'b0000;
    load(3, 32'h02000099);
    load(0, 32'h02000011);
    reset = 1'b1;
    obs_push.delete();
    obs_pop.delete();
    exp_push.push_back(push_t'{4'b0100, 32'h02000011});
    exp_push.push_back(push_t'{4'b0100, 32'h02000099});
    run_idle(100, to);
    checks++; if (to) begin failures++; $display("FAIL mid_timeout got=busy want=idle"); end
    checks++;
    if (obs_pop.size() == 0 || obs_pop[0].idx != 0) begin
      failures++; $display("FAIL mid_first_grant got=%0d want=0", (obs_pop.size() > 0) ? obs_pop[0].idx : -1);
    end
    while (exp_push.size() > 0) begin
      push_t e, o;
      e = exp_push.pop_front();
      checks++;
      if (obs_push.size() == 0) begin
        failures++; $display("FAIL mid_push got=none want=%b/%h", e.mask, e.data);
      end else begin
        o = obs_push.pop_front();
        if (o.mask !== e.mask || o.data !== e.data) begin
          failures++; $display("FAIL mid_push got=%b/%h want=%b/%h", o.mask, o.data, e.mask, e.data);
        end
      end
    end
    checks++; if (pkt_cnt !== 16'd2) begin failures++; $display("FAIL mid_cnt_after got=%0d want=2", pkt_cnt); end
  endtask

  task automatic test_back_to_back();
    checks++; if (overlap != 0) begin failures++; $display("FAIL pop_push_overlap got=%0d want=0", overlap); end
  endtask

  initial begin
    reset = 1'b0;
    full  = 4'b0;
    pndng = 4'b0;
    D_pop = '0;
    test_reset();
    test_single();
    test_rr_fairness();
    test_broadcast();
    test_backpressure();
    test_invalid_id();
`ifdef BUS_RR_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
